// File: rtl/collector3x3_pkg.sv
// Shared definitions for the 3x3 window collector: pixel width and the
// width helper used for the stage width input and the position counters.
package collector3x3_pkg;

    localparam int PIX_W = 8;

    // Bits needed to hold any value 0..depth inclusive (row length itself
    // must be representable, not only the last index).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/collector3x3_line_buffer.sv
// One image row of pixel storage. Single address per cycle: the old
// contents are read combinationally and replaced by the new pixel on the
// same edge, so a read always returns the value from one row earlier.
module line_buffer
    import collector3x3_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wr_data_i,
    output logic [PIX_W-1:0] rd_data_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Read-before-write: the read below sees the value being overwritten.
    assign rd_data_o = mem_q[addr_i];

    // Replace the entry at the current column with the incoming pixel.
    always_ff @(posedge clk) begin
        mem_q[addr_i] <= wr_data_i;
    end

endmodule

// File: rtl/collector3x3.sv
// Streaming 3x3 window generator. Takes one pixel per clock in raster
// order, keeps the two previous rows in line buffers and presents the
// neighbourhood ending at the newest pixel, with a stall flag marking
// windows that are not fully inside the current frame.
module collector3x3
    import collector3x3_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = IMAGE_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PIX_W-1:0]                    pixel_in,
    input  logic [cnt_width(IMAGE_WIDTH)-1:0]   stage_width,
    output logic [PIX_W-1:0]                    out1,
    output logic [PIX_W-1:0]                    out2,
    output logic [PIX_W-1:0]                    out3,
    output logic [PIX_W-1:0]                    out4,
    output logic [PIX_W-1:0]                    out5,
    output logic [PIX_W-1:0]                    out6,
    output logic [PIX_W-1:0]                    out7,
    output logic [PIX_W-1:0]                    out8,
    output logic [PIX_W-1:0]                    out9,
    output logic                                stall
);

    localparam int CW     = cnt_width(IMAGE_WIDTH);
    localparam int MAX_HW = (IMAGE_HEIGHT > IMAGE_WIDTH) ? IMAGE_HEIGHT : IMAGE_WIDTH;
    localparam int RW     = cnt_width(MAX_HW);
    localparam int AW     = $clog2(IMAGE_WIDTH);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             stall_q, stall_d;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];

    logic [CW-1:0]    last_idx;
    logic             col_wrap;
    logic             row_last;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // The active frame is square: the same last index closes rows and columns.
    assign last_idx = stage_width - CW'(1);
    assign col_wrap = (col_q == last_idx);
    assign row_last = (row_q == RW'(last_idx));

    // LB0 holds the previous row; LB1 is fed from LB0 and so holds the row
    // before that. Both share the column address.
    line_buffer #(.DEPTH(IMAGE_WIDTH), .AW(AW)) u_lb0 (
        .clk       (clk),
        .addr_i    (col_q[AW-1:0]),
        .wr_data_i (pixel_in),
        .rd_data_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMAGE_WIDTH), .AW(AW)) u_lb1 (
        .clk       (clk),
        .addr_i    (col_q[AW-1:0]),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    // Next position, validity of the pixel being sampled, and window shift.
    always_comb begin
        col_d = col_wrap ? '0 : col_q + CW'(1);
        row_d = row_q;
        if (col_wrap) begin
            row_d = row_last ? '0 : row_q + RW'(1);
        end

        // Complete only once two full rows and two columns are behind us.
        stall_d = !((row_q >= RW'(2)) && (col_q >= CW'(2)));

        // Each window row shifts left; the newest column enters on the right.
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = lb1_rd;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = lb0_rd;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = pixel_in;
    end

    // Position counters, stall flag and window registers; reset restarts
    // the frame at row 0, col 0 with an empty, stalled window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            stall_q <= 1'b1;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            stall_q <= stall_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign out1  = win_q[0];
    assign out2  = win_q[1];
    assign out3  = win_q[2];
    assign out4  = win_q[3];
    assign out5  = win_q[4];
    assign out6  = win_q[5];
    assign out7  = win_q[6];
    assign out8  = win_q[7];
    assign out9  = win_q[8];
    assign stall = stall_q;

endmodule

// File: tb/tb_collector3x3.sv
// Directed bench for collector3x3: reset state, column and row ramps,
// warm-up counts, mid-frame reset and the minimum stage width.
module tb_collector3x3;
    import collector3x3_pkg::*;

    localparam int W  = 128;
    localparam int CW = cnt_width(W);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PIX_W-1:0] pixel_in = '0;
    logic [CW-1:0]    stage_width = CW'(W);
    logic [PIX_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic             stall;
    logic [71:0]      win;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    collector3x3 #(.IMAGE_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_in    (pixel_in),
        .stage_width (stage_width),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .out4        (out4),
        .out5        (out5),
        .out6        (out6),
        .out7        (out7),
        .out8        (out8),
        .out9        (out9),
        .stall       (stall)
    );

    assign win = {out1, out2, out3, out4, out5, out6, out7, out8, out9};

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one pixel, let it be sampled, then settle away from the edge.
    task automatic step(input logic [7:0] pix);
        pixel_in = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int width, input int edges);
        stage_width = CW'(width);
        rst_n = 1'b0;
        repeat (edges) step(8'h00);
        rst_n = 1'b1;
    endtask

    function automatic logic [71:0] same_rows(input logic [7:0] l, input logic [7:0] m,
                                              input logic [7:0] r);
        return {l, m, r, l, m, r, l, m, r};
    endfunction

    function automatic logic [71:0] same_cols(input logic [7:0] t, input logic [7:0] m,
                                              input logic [7:0] b);
        return {t, t, t, m, m, m, b, b, b};
    endfunction

    initial begin
        int first_valid;
        int nvalid;
        int k;
        logic exp_stall;

        // Reset state
        do_reset(W, 2);
        chk("reset_win", win, 72'h0);
        chk("reset_stall", {71'h0, stall}, 72'h1);

        // Column ramp at full width: every column of a valid window matches its index
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                step(8'(c));
                exp_stall = !(r >= 2 && c >= 2);
                chk("colramp_stall", {71'h0, stall}, {71'h0, exp_stall});
                if (!exp_stall)
                    chk("colramp_win", win, same_rows(8'(c - 2), 8'(c - 1), 8'(c)));
            end
        end

        // Row ramp at width 8 over two frames, with warm-up and valid counts
        do_reset(8, 1);
        for (int f = 0; f < 2; f++) begin
            first_valid = 0;
            nvalid = 0;
            k = 0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    step(8'(r));
                    k++;
                    exp_stall = !(r >= 2 && c >= 2);
                    chk("rowramp_stall", {71'h0, stall}, {71'h0, exp_stall});
                    if (!stall) begin
                        nvalid++;
                        if (first_valid == 0) first_valid = k;
                        chk("rowramp_win", win, same_cols(8'(r - 2), 8'(r - 1), 8'(r)));
                    end
                end
            end
            chk("warmup_first", 72'(first_valid), 72'd19);
            chk("warmup_nvalid", 72'(nvalid), 72'd36);
        end

        // Spot check from the row ramp example: row 5 window
        do_reset(8, 1);
        for (int n = 0; n < 5 * 8 + 3; n++) step(8'(n / 8));
        chk("row5_win", win, {8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5, 8'd5, 8'd5});
        chk("row5_stall", {71'h0, stall}, 72'h0);

        // Reset mid-frame at row 3, col 4
        do_reset(8, 1);
        for (int n = 0; n < 3 * 8 + 4; n++) step(8'(n + 100));
        chk("midrst_pre_stall", {71'h0, stall}, 72'h0);
        rst_n = 1'b0;
        step(8'hAA);
        rst_n = 1'b1;
        chk("midrst_win", win, 72'h0);
        chk("midrst_stall", {71'h0, stall}, 72'h1);
        for (int n = 1; n <= 2 * 8 + 3; n++) begin
            step(8'(n));
            chk("midrst_recover", {71'h0, stall}, {71'h0, (n <= 2 * 8 + 2)});
        end

        // Minimum width: 3x3 frame, pixels counting up
        do_reset(3, 1);
        for (int n = 0; n < 18; n++) begin
            step(8'(n));
            exp_stall = !(((n % 9) / 3) >= 2 && (n % 3) >= 2);
            chk("w3_stall", {71'h0, stall}, {71'h0, exp_stall});
            if (n == 8)
                chk("w3_win_f0", win, {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
            if (n == 17)
                chk("w3_win_f1", win, {8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
